complex_result_accumulator: RTL
===============================

# complex_result_accumulator

Downstream stage of the complex-number multiplier. Consumes the stream of complex products (`{re, im}`, each 2*DATA_WIDTH) over a valid/ready handshake. It accumulates a programmable block of products into widened signed real and imaginary sums, for dot products and correlations. It then presents the block sum on a second valid/ready output.

## Interface
- DATA_WIDTH, 8, operand width of the multiplier; each product component is 2*DATA_WIDTH bits
- LEN_WIDTH, 4, width of block-length field; max block = 2^LEN_WIDTH-1 products; guard bits added to sums
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  reset, synchronous, active-low
- sw_rst  input  1  software reset, synchronous, active-high; same effect as rstn; rstn has priority
- blk_len  input  LEN_WIDTH  products per block; sampled on first accepted beat of each block
- in_val  input  1  product valid (from multiplier res_val)
- in_ready  output  1  accumulator can take a product (to multiplier res_ready)
- in_data  input  4*DATA_WIDTH  product; [4*DW-1:2*DW] = re, [2*DW-1:0] = im; two's complement
- acc_val  output  1  block sum valid
- acc_ready  input  1  consumer accepts block sum
- acc_data  output  2*ACC_W  {acc_re, acc_im}; ACC_W = 2*DATA_WIDTH+LEN_WIDTH; two's complement

## Operation
- Two states: ACCUM (in_ready=1, acc_val=0) and HOLD (in_ready=0, acc_val=1).
- Transfer on input when in_val & in_ready at a clock edge; on output when acc_val & acc_ready.
- Registers: acc_re, acc_im (ACC_W each), beat counter cnt (LEN_WIDTH), latched length len_q (LEN_WIDTH).
- First beat of block (cnt==0): len_q <= (blk_len==0) ? 1 : blk_len; blk_len changes at other times are ignored.
- Each accepted beat: sign-extend re and im to ACC_W and add to acc_re/acc_im. On the first beat the accumulators are loaded, not added, so there is no stale data.
- Last beat: when cnt == eff_len-1, where eff_len is len_q or the just-sampled value if first beat. State goes to HOLD and cnt is cleared; otherwise cnt increments.
- HOLD: acc_data is stable. On acc_ready the state goes to ACCUM and the sums are kept until the next first beat overwrites them.
- Arithmetic: modulo 2^ACC_W. It never overflows for blocks up to 2^LEN_WIDTH-1 beats of full-scale inputs.
- Reset (rstn=0 or sw_rst=1): state ACCUM, cnt=0, len_q=0, acc_re=acc_im=0. A partial block is discarded; a held result is dropped.
- Reset values of outputs: in_ready=1 once state is ACCUM (combinational from state), acc_val=0, acc_data=0.

## Timing
- in_ready and acc_val are decoded from the state register only, never from in_val or acc_ready (no combinational path through the block).
- Throughput: one product per cycle in ACCUM.
- Latency: last beat accepted at edge k, so acc_val=1 from edge k onward. The consumer may accept in the same cycle. On acc_ready at edge m, in_ready=1 after m, so the minimum gap between blocks is one cycle.
- Upstream must hold in_val/in_data until accepted; downstream back-pressure stalls upstream via in_ready=0.
- sw_rst in the same cycle as an accepted beat: reset wins, the beat is lost.

## Structure
- Shared package complex_pkg: DATA_WIDTH/LEN_WIDTH defaults, ACC_W derivation function, state encoding (ACCUM=1'b0, HOLD=1'b1).
- One sub-module, complex_sext_add: combinational sign-extend of one 2*DW component plus ACC_W add with load/add select. Instantiated twice (re, im).
- Top holds FSM, counter, length latch and registers.

## Test plan
- Reset: hold rstn=0 for 2 cycles. Then in_ready=1, acc_val=0, acc_data=0.
- blk_len=3, beats (0x0010,0x0001), (0xFFFF,0x0002), (0x0100,0xFFFE) -> acc_data={20'h0010F, 20'h00001}. acc_val rises the cycle after the 3rd beat.
- blk_len=0, one beat (0x1234,0x8000) -> treated as length 1. acc_data={20'h01234, 20'hF8000}.
- Back-pressure: blk_len=1, acc_ready=0 for 5 cycles -> in_ready=0, acc_data stable throughout. Then acc_ready=1 -> in_ready=1 next cycle, next block starts fresh.
- Full scale: blk_len=15, fifteen beats (0x8000,0x7FFF) -> acc_data={20'h88000, 20'h77FF1}, no wrap.
- sw_rst after 2 of 4 beats, then 4 new beats of (0x0001,0x0001) with blk_len=4 -> acc_data={20'h00004, 20'h00004}. The earlier partial block is discarded; blk_len changes mid-block have no effect.

Source files
------------

// File: rtl/complex_pkg.sv
// complex_pkg: shared widths, accumulator width derivation and FSM encoding
// for the complex-product accumulator.
package complex_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Guard bits cover the worst-case growth of a maximum-length block.
    function automatic int acc_w(input int dw, input int lw);
        return 2 * dw + lw;
    endfunction
endpackage

// File: rtl/complex_sext_add.sv
// complex_sext_add: sign-extend one product component to the accumulator
// width and either load it or add it to the running sum.
module complex_sext_add #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 20
)(
    input  logic [IN_W-1:0]  i_val,
    input  logic [ACC_W-1:0] i_acc,
    input  logic             i_load,
    output logic [ACC_W-1:0] o_sum
);
    logic [ACC_W-1:0] w_ext;

    assign w_ext = {{(ACC_W-IN_W){i_val[IN_W-1]}}, i_val};
    assign o_sum = w_ext + (i_load ? '0 : i_acc);
endmodule

// File: rtl/complex_result_accumulator.sv
// complex_result_accumulator: sums a programmable block of complex products
// into widened real/imaginary accumulators and holds the result for a consumer.
module complex_result_accumulator
    import complex_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    localparam int CW        = 2 * DATA_WIDTH,
    localparam int ACC_W     = acc_w(DATA_WIDTH, LEN_WIDTH)
)(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_sw_rst,
    input  logic [LEN_WIDTH-1:0]  i_blk_len,
    input  logic                  i_in_val,
    output logic                  o_in_ready,
    input  logic [2*CW-1:0]       i_in_data,
    output logic                  o_acc_val,
    input  logic                  i_acc_ready,
    output logic [2*ACC_W-1:0]    o_acc_data
);
    acc_state_t           r_state;
    acc_state_t           w_state_nxt;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [ACC_W-1:0]     r_acc_re;
    logic [ACC_W-1:0]     r_acc_im;
    logic [ACC_W-1:0]     w_sum_re;
    logic [ACC_W-1:0]     w_sum_im;
    logic [LEN_WIDTH-1:0] w_len_new;
    logic [LEN_WIDTH-1:0] w_eff_len;
    logic                 w_first;
    logic                 w_last;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_rst;

    assign w_rst      = !i_rstn || i_sw_rst;
    assign w_in_fire  = i_in_val && o_in_ready;
    assign w_out_fire = o_acc_val && i_acc_ready;
    assign w_first    = r_cnt == '0;
    assign w_len_new  = (i_blk_len == '0) ? LEN_WIDTH'(1) : i_blk_len;
    assign w_eff_len  = w_first ? w_len_new : r_len;
    assign w_last     = r_cnt == LEN_WIDTH'(w_eff_len - 1'b1);
    assign o_acc_data = {r_acc_re, r_acc_im};

    complex_sext_add #(.IN_W(CW), .ACC_W(ACC_W)) u_add_re (
        .i_val  (i_in_data[2*CW-1:CW]),
        .i_acc  (r_acc_re),
        .i_load (w_first),
        .o_sum  (w_sum_re)
    );

    complex_sext_add #(.IN_W(CW), .ACC_W(ACC_W)) u_add_im (
        .i_val  (i_in_data[CW-1:0]),
        .i_acc  (r_acc_im),
        .i_load (w_first),
        .o_sum  (w_sum_im)
    );

    always_ff @(posedge i_clk) begin
        if (w_rst) r_state <= ACCUM;
        else       r_state <= w_state_nxt;
    end

    // Handshake outputs come from the state alone, so no input-to-output path exists.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = r_state == ACCUM;
        o_acc_val   = r_state == HOLD;
        if (r_state == ACCUM && w_in_fire && w_last) w_state_nxt = HOLD;
        if (r_state == HOLD && w_out_fire)           w_state_nxt = ACCUM;
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_cnt    <= '0;
            r_len    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (w_in_fire) begin
            r_acc_re <= w_sum_re;
            r_acc_im <= w_sum_im;
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_first) r_len <= w_len_new;
        end
    end
endmodule
